// File: rtl/arith_pkg.sv
// Shared arithmetic-library types: serial datapath FSM states and count-width helper.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

    // Bit-counter width for a WIDTH-bit serial operation (at least one bit).
    function automatic int unsigned cnt_w(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_sub_if.sv
// Start/done handshake and operand/result bus of the bit-serial subtractor.
// Optional SERIAL_SUB_SIGNED_OVF_EN adds the signed-overflow flag ovf.
interface serial_sub_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b,
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        input  ovf,
`endif
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b,
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        output ovf,
`endif
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_sub_fs.sv
// Combinational 1-bit full subtractor: d = x - y - bin, with borrow out.
module fs (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b, LSB first) with start/done handshake.
// Define SERIAL_SUB_SIGNED_OVF_EN to add the two's-complement overflow output ovf.
module serial_sub
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    serial_sub_if.slave bus
);
    localparam int unsigned    CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    logic fs_d;
    logic fs_bout;

    fs u_fs (
        .x    (a_sr_q[0]),
        .y    (b_sr_q[0]),
        .bin  (borrow_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sr_d   = bus.a;
                    b_sr_d   = bus.b;
                    res_d    = '0;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = RUN;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                    a_msb_d  = bus.a[WIDTH-1];
                    b_msb_d  = bus.b[WIDTH-1];
`endif
                end
            end
            RUN: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                res_d    = {fs_d, res_q[WIDTH-1:1]};
                borrow_d = fs_bout;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    diff_d  = {fs_d, res_q[WIDTH-1:1]};
                    bout_d  = fs_bout;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                    // fs_d is the result MSB on the final bit.
                    ovf_d   = (a_msb_q != b_msb_q) && (fs_d != a_msb_q);
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub (WIDTH=8); checks ovf when SERIAL_SUB_SIGNED_OVF_EN is defined.
module tb_serial_sub;
    localparam int unsigned W = 8;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;
    exp_t sb_q[$];

    serial_sub_if #(.WIDTH(W)) bus ();

    serial_sub #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [W:0] full;
        full   = {1'b0, a} - {1'b0, b};
        e.diff = full[W-1:0];
        e.bout = (a < b);
        e.ovf  = (a[W-1] != b[W-1]) && (e.diff[W-1] != a[W-1]);
        return e;
    endfunction

    // Result monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            exp_t e;
            done_cnt++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("diff", 32'(bus.diff), 32'(e.diff));
                check("bout", 32'(bus.bout), 32'(e.bout));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                check("ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
            end
        end
    end

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Full operation with latency/busy-width checks; returns at negedge one cycle after DONE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int edges;
        int busy_cnt;
        exp_t e;
        e = model(a, b);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        sb_q.push_back(e);
        @(posedge clk);
        edges    = 0;
        busy_cnt = 0;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        if (bus.busy === 1'b1) busy_cnt++;
        while (bus.done !== 1'b1 && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (bus.busy === 1'b1) busy_cnt++;
        end
        check("latency", 32'(edges), 32'(W));
        check("busy_cycles", 32'(busy_cnt), 32'(W));
        @(negedge clk);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("hold_diff", 32'(bus.diff), 32'(e.diff));
    endtask

    initial begin
        int dc;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_diff", 32'(bus.diff), 32'd0);
        check("rst_bout", 32'(bus.bout), 32'd0);
        rst = 1'b0;
        idle_cycles(1);

        run_op(8'h5A, 8'h23);
        run_op(8'h10, 8'h20);
        run_op(8'hFF, 8'h01);
        run_op(8'h00, 8'h00);

        // Starts during RUN and DONE are ignored.
        dc = done_cnt;
        bus.a = 8'h05; bus.b = 8'h03; bus.start = 1'b1;
        sb_q.push_back(model(8'h05, 8'h03));
        @(negedge clk);
        bus.start = 1'b0;
        idle_cycles(2);
        bus.a = 8'hAA; bus.b = 8'h11; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 20 && bus.done !== 1'b1; i++) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("ignored_busy", 32'(bus.busy), 32'd0);
        idle_cycles(12);
        check("single_done", 32'(done_cnt - dc), 32'd1);
        check("ignored_diff", 32'(bus.diff), 32'h02);
        run_op(8'hAA, 8'h11);

        // Reset in the middle of RUN aborts without a done pulse.
        dc = done_cnt;
        bus.a = 8'h12; bus.b = 8'h34; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        idle_cycles(3);
        check("mid_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_diff", 32'(bus.diff), 32'd0);
        check("abort_bout", 32'(bus.bout), 32'd0);
        idle_cycles(12);
        check("abort_no_done", 32'(done_cnt - dc), 32'd0);
        run_op(8'h40, 8'h01);

        // rst wins over a simultaneous start.
        dc = done_cnt;
        rst = 1'b1; bus.start = 1'b1; bus.a = 8'h33; bus.b = 8'h11;
        @(negedge clk);
        rst = 1'b0; bus.start = 1'b0;
        check("rst_start_busy", 32'(bus.busy), 32'd0);
        idle_cycles(12);
        check("rst_start_no_done", 32'(done_cnt - dc), 32'd0);

        run_op(8'h80, 8'h01);
        run_op(8'h7F, 8'hFF);
        run_op(8'h05, 8'h03);
        for (int i = 0; i < 6; i++) run_op(W'($urandom), W'($urandom));

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
